fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_pc_reg.sv | 28 ++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, FSM states
// and the opcode constants the fetch path needs to know about.
package fetch_unit_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_LDB = 4'b0001;
  localparam logic [3:0] OP_LDO = 4'b0010;
  localparam logic [3:0] OP_CLR = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1110;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: jump load, increment with natural wrap, async clear to 0.
module fetch_unit_pc_reg #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Load and increment are never requested together; load takes priority anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a synchronous program ROM and hands one
// instruction at a time to the decoder with a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for run (halt wins)
// ISSUE   | PC on rom_addr, ROM samples it at the closing edge
// CAPTURE | ROM data arrives; IR/instr_pc captured, PC incremented
// HOLD    | instr_valid; wait for decoder handshake, optional jump
// HALT    | absorbing stop state, left only by reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              halt,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              halted
);

  state_t            r_state;
  state_t            w_next;
  logic              w_capture;
  logic              w_pc_load;
  logic [ADDR_W-1:0] w_pc;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_pc_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (halt) begin
          w_next = ST_HALT;
        end else if (run) begin
          w_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = ST_HOLD;
      end
      ST_HOLD: begin
        // Jump and halt are both honoured only on the handshake cycle.
        if (instr_ready) begin
          w_pc_load = jump_valid;
          w_next    = halt ? ST_HALT : ST_ISSUE;
        end
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  fetch_unit_pc_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_pc_load),
    .i_load_addr (jump_addr),
    .i_inc       (w_capture),
    .o_pc        (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= DATA_W'(OP_CLR);
      r_instr_pc <= '0;
    end else if (w_capture) begin
      r_instr    <= rom_data;
      r_instr_pc <= w_pc;
    end
  end

  assign rom_addr    = w_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == ST_HOLD);
  assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a fetch-order model predicts each delivered
// instruction and its timing; a negedge monitor compares what the DUT presents.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, halt, instr_ready, jump_valid;
  logic [3:0] jump_addr;
  logic [3:0] rom_addr, rom_data, instr, instr_pc;
  logic       instr_valid, halted;

  logic [3:0] rom [16];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] ins;
  } exp_t;

  exp_t       q[$];
  logic [3:0] m_pc;
  bit         m_active, m_halted;
  int         cyc, m_due;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .halt        (halt),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Synchronous program ROM: data valid one cycle after the address is sampled.
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model. The model only knows the fetch rules: the
  // first fetch is from 0, each accepted instruction is followed by the one at
  // pc+1 or at the jump target, the next one shows up 3 cycles after the
  // handshake, and halt at a handshake (or in idle) stops everything.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] nx;
    bit         ev;
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_pc     = 4'd0;
      m_active = 1'b0;
      m_halted = 1'b0;
      m_due    = 0;
    end else begin
      ev = m_active && !m_halted && (cyc >= m_due);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, ev});
      chk("halted", {31'd0, halted}, {31'd0, m_halted});
      if (ev && instr_valid) begin
        if (q.size() == 0) begin
          chk("queue_empty", 32'd1, 32'd0);
        end else begin
          nx = q[0].pc + 4'd1;
          chk("instr_pc", {28'd0, instr_pc}, {28'd0, q[0].pc});
          chk("instr", {28'd0, instr}, {28'd0, q[0].ins});
          chk("rom_addr_hold", {28'd0, rom_addr}, {28'd0, nx});
          if (instr_ready) begin
            e    = q.pop_front();
            m_pc = jump_valid ? jump_addr : e.pc + 4'd1;
            if (halt) begin
              m_halted = 1'b1;
            end else begin
              q.push_back('{pc: m_pc, ins: rom[m_pc]});
              m_due = cyc + 3;
            end
          end
        end
      end else if (!m_active || m_halted) begin
        chk("rom_addr_idle", {28'd0, rom_addr}, {28'd0, m_pc});
      end
      if (!m_active && !m_halted) begin
        if (halt) begin
          m_halted = 1'b1;
        end else if (run) begin
          m_active = 1'b1;
          m_due    = cyc + 3;
          q.push_back('{pc: m_pc, ins: rom[m_pc]});
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_spec_rom();
    for (int i = 0; i < 16; i++) rom[i] = 4'b0111;
    rom[0] = 4'b0000;
    rom[1] = 4'b0001;
    rom[2] = 4'b1110;
    rom[3] = 4'b0010;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    run         = 1'b0;
    halt        = 1'b0;
    instr_ready = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = 4'd0;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid_pc(input logic [3:0] pc);
    int n;
    n = 0;
    while (!(instr_valid === 1'b1 && instr_pc === pc) && n < 60) begin
      cycle();
      n++;
    end
    if (n >= 60) chk("wait_pc_timeout", {28'd0, instr_pc}, {28'd0, pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    load_spec_rom();
    rst_n       = 1'b0;
    run         = 1'b0;
    halt        = 1'b0;
    instr_ready = 1'b0;
    jump_valid  = 1'b0;
    jump_addr   = 4'd0;
    repeat (3) cycle();
    chk("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    chk("rst_instr", {28'd0, instr}, 32'd7);
    chk("rst_instr_pc", {28'd0, instr_pc}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    repeat (3) cycle();

    // Free run with ready high: sequence, 3-cycle cadence and PC wrap.
    run         = 1'b1;
    instr_ready = 1'b1;
    repeat (20 * 3 + 4) cycle();

    // Stall on pc 1, then a jump back to 0 on pc 2, then a jump in CAPTURE.
    do_reset();
    run         = 1'b1;
    instr_ready = 1'b1;
    wait_valid_pc(4'd1);
    instr_ready = 1'b0;
    repeat (5) cycle();
    instr_ready = 1'b1;
    wait_valid_pc(4'd2);
    jump_valid = 1'b1;
    jump_addr  = 4'd0;
    cycle();
    jump_valid = 1'b0;
    cycle();
    jump_valid = 1'b1;
    jump_addr  = 4'd5;
    cycle();
    jump_valid = 1'b0;
    repeat (12) cycle();

    // Randomized ROM contents, ready and jumps.
    for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      instr_ready = 1'($urandom_range(0, 1));
      jump_valid  = ($urandom_range(0, 3) == 0);
      jump_addr   = 4'($urandom);
      run         = ($urandom_range(0, 7) != 0);
      cycle();
    end

    // Halt raised during ISSUE of pc 3.
    load_spec_rom();
    do_reset();
    run         = 1'b1;
    instr_ready = 1'b1;
    wait_valid_pc(4'd2);
    cycle();
    halt = 1'b1;
    repeat (15) cycle();
    chk("halt_rom_addr", {28'd0, rom_addr}, 32'd4);

    // Halt together with a jump to 9.
    do_reset();
    run         = 1'b1;
    instr_ready = 1'b1;
    cycle();
    halt       = 1'b1;
    jump_valid = 1'b1;
    jump_addr  = 4'd9;
    repeat (10) cycle();
    chk("halt_jump_rom_addr", {28'd0, rom_addr}, 32'd9);

    // Halt while idle wins over run.
    do_reset();
    halt = 1'b1;
    run  = 1'b1;
    repeat (5) cycle();

    // Reset asserted in CAPTURE of pc 2 discards it; restart from 0.
    do_reset();
    run         = 1'b1;
    instr_ready = 1'b1;
    wait_valid_pc(4'd1);
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_instr", {28'd0, instr}, 32'd7);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_rom_addr", {28'd0, rom_addr}, 32'd0);
    chk("midrst_instr_pc", {28'd0, instr_pc}, 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (15) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
